// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: bundles the decode-stage flags, interrupt line, redirect
// outputs and MRS read path of the LEGv8 exception controller.
//   slave  modport : used by exception_ctrl (consumes flags, drives redirect/MRS)
//   master modport : used by the pipeline side (drives flags, consumes redirect/MRS)
interface exception_ctrl_if #(
  parameter int unsigned N = 64
);
  logic         valid_i;
  logic [N-1:0] pc_i;
  logic         not_an_instr_i;
  logic         eret_i;
  logic         irq_i;
  logic         irq_ack_o;
  logic         redirect_o;
  logic [N-1:0] redirect_pc_o;
  logic         flush_o;
  logic         in_handler_o;
  logic         fatal_o;
  logic [1:0]   mrs_sel_i;
  logic [N-1:0] mrs_data_o;

  modport slave (
    input  valid_i, pc_i, not_an_instr_i, eret_i, irq_i, mrs_sel_i,
    output irq_ack_o, redirect_o, redirect_pc_o, flush_o, in_handler_o,
           fatal_o, mrs_data_o
  );

  modport master (
    output valid_i, pc_i, not_an_instr_i, eret_i, irq_i, mrs_sel_i,
    input  irq_ack_o, redirect_o, redirect_pc_o, flush_o, in_handler_o,
           fatal_o, mrs_data_o
  );
endinterface

// File: rtl/exception_ctrl.sv
// exception_ctrl: sequences exception entry/return for the LEGv8 core.
// Captures the faulting PC (ELR) and a syndrome (ESR), redirects fetch to
// VECTOR_ADDR with a flush, returns to ELR on ERET, and latches a sticky
// fatal flag on a fault taken inside the handler.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - exception_ctrl_if.slave: valid_i, pc_i, not_an_instr_i, eret_i,
//           irq_i, mrs_sel_i in; irq_ack_o, redirect_o, redirect_pc_o,
//           flush_o, in_handler_o, fatal_o, mrs_data_o out
module exception_ctrl #(
  parameter int unsigned  N           = 64,
  parameter logic [N-1:0] VECTOR_ADDR = 64'h00000000000000D8
) (
  input  logic                  clk,
  input  logic                  reset,
  exception_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    RUN,
    TAKE,
    HANDLER,
    RET,
    HALT
  } state_t;

  localparam logic [3:0] ESR_UNDEF = 4'h1;
  localparam logic [3:0] ESR_IRQ   = 4'h2;
  localparam logic [3:0] ESR_ERET  = 4'h3;
  localparam logic [3:0] ESR_FATAL = 4'hF;

  state_t       r_state;
  logic [N-1:0] r_elr;
  logic [3:0]   r_esr;
  logic         r_fatal;

  state_t       w_state_nxt;
  logic [N-1:0] w_elr_nxt;
  logic [3:0]   w_esr_nxt;
  logic         w_fatal_nxt;
  logic         w_irq_ack;
  logic         w_redirect;
  logic         w_flush;
  logic [N-1:0] w_redirect_pc;
  logic         w_in_handler;
  logic         w_undef;
  logic         w_eret;
  logic [N-1:0] w_mrs_data;

  // Instruction-sourced flags only count when the stage holds a real instruction.
  assign w_undef = bus.valid_i & bus.not_an_instr_i;
  assign w_eret  = bus.valid_i & bus.eret_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_elr   <= '0;
      r_esr   <= '0;
      r_fatal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elr   <= w_elr_nxt;
      r_esr   <= w_esr_nxt;
      r_fatal <= w_fatal_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_elr_nxt     = r_elr;
    w_esr_nxt     = r_esr;
    w_fatal_nxt   = r_fatal;
    w_irq_ack     = 1'b0;
    w_redirect    = 1'b0;
    w_flush       = 1'b0;
    w_redirect_pc = '0;
    w_in_handler  = 1'b0;
    unique case (r_state)
      RUN: begin
        // Undefined opcode beats ERET, and any instruction exception beats IRQ.
        if (w_undef) begin
          w_elr_nxt   = bus.pc_i;
          w_esr_nxt   = ESR_UNDEF;
          w_state_nxt = TAKE;
        end else if (w_eret) begin
          w_elr_nxt   = bus.pc_i;
          w_esr_nxt   = ESR_ERET;
          w_state_nxt = TAKE;
        end else if (bus.irq_i) begin
          w_elr_nxt   = bus.pc_i;
          w_esr_nxt   = ESR_IRQ;
          w_irq_ack   = 1'b1;
          w_state_nxt = TAKE;
        end
      end
      TAKE: begin
        w_redirect    = 1'b1;
        w_flush       = 1'b1;
        w_redirect_pc = VECTOR_ADDR;
        w_state_nxt   = HANDLER;
      end
      HANDLER: begin
        w_in_handler = 1'b1;
        // IRQ is masked here; the source keeps it pending until RUN.
        if (w_undef) begin
          w_esr_nxt   = ESR_FATAL;
          w_fatal_nxt = 1'b1;
          w_state_nxt = HALT;
        end else if (w_eret) begin
          w_state_nxt = RET;
        end
      end
      RET: begin
        w_redirect    = 1'b1;
        w_flush       = 1'b1;
        w_redirect_pc = r_elr;
        w_state_nxt   = RUN;
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    w_mrs_data = '0;
    unique case (bus.mrs_sel_i)
      2'b00:   w_mrs_data = r_elr;
      2'b01:   w_mrs_data = {{(N-4){1'b0}}, r_esr};
      2'b10:   w_mrs_data = {{(N-2){1'b0}}, r_fatal, w_in_handler};
      default: w_mrs_data = '0;
    endcase
  end

  // The ack is a combinational pulse; suppress it while reset is overriding the FSM.
  assign bus.irq_ack_o     = w_irq_ack & ~reset;
  assign bus.redirect_o    = w_redirect;
  assign bus.flush_o       = w_flush;
  assign bus.redirect_pc_o = w_redirect_pc;
  assign bus.in_handler_o  = w_in_handler;
  assign bus.fatal_o       = r_fatal;
  assign bus.mrs_data_o    = w_mrs_data;

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Sequences exception entry and return for the LEGv8 core.
- Consumes the NotAnInstr and ERet flags from the main decoder plus an external interrupt line.
- Captures the faulting PC (ELR) and a syndrome code (ESR), then redirects fetch to the exception vector and flushes younger instructions.
- Handles ERET back to ELR and serves ELR/ESR/status to the MRS read path.

Parameters:
- N, 64, datapath/PC width in bits.
- VECTOR_ADDR, 64'h00000000000000D8, exception vector PC.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; wins over every other input.
- valid_i  input  1  decoded instruction in the stage is real; 0 means bubble/stall, and all instruction-sourced inputs are ignored.
- pc_i  input  N  PC of the instruction currently qualified by valid_i.
- not_an_instr_i  input  1  decoder flag, invalid opcode.
- eret_i  input  1  decoder flag, ERET instruction.
- irq_i  input  1  external interrupt request, level-sensitive.
- irq_ack_o  output  1  one-cycle pulse when an IRQ is accepted.
- redirect_o  output  1  one-cycle pulse: fetch must load redirect_pc_o.
- redirect_pc_o  output  N  target PC, valid while redirect_o=1, else 0.
- flush_o  output  1  squash younger in-flight instructions, same cycle as redirect_o.
- in_handler_o  output  1  controller is in HANDLER state.
- fatal_o  output  1  sticky double-fault indicator.
- mrs_sel_i  input  2  system register select for MRS.
- mrs_data_o  output  N  system register read data, combinational.

Behaviour:
- Internal registers: state, elr[N], esr[3:0].
- Reset: state=RUN, elr=0, esr=0, fatal_o=0, all pulses 0, in_handler_o=0, redirect_pc_o=0.
- States: RUN, TAKE, HANDLER, RET, HALT.
- RUN, evaluated every cycle, in priority order:
  - valid_i & not_an_instr_i -> elr<=pc_i, esr<=4'h1, go TAKE.
  - else valid_i & eret_i (ERET outside handler is illegal) -> elr<=pc_i, esr<=4'h3, go TAKE.
  - else irq_i -> elr<=pc_i, esr<=4'h2, irq_ack_o=1 this cycle, go TAKE.
  - else stay RUN.
- TAKE: redirect_o=1, flush_o=1, redirect_pc_o=VECTOR_ADDR; next state HANDLER. Inputs are ignored in this cycle.
- HANDLER: in_handler_o=1; irq_i is masked (no ack, stays pending at source).
  - valid_i & not_an_instr_i -> esr<=4'hF, fatal_o<=1, go HALT; elr is not overwritten.
  - else valid_i & eret_i -> go RET.
  - else stay.
- RET: redirect_o=1, flush_o=1, redirect_pc_o=elr; next state RUN.
  - ERET resumes at the faulting PC; the handler is responsible for adjusting ELR semantics.
  - An irq_i asserted during RET is sampled in the following RUN cycle.
- HALT: fatal_o=1, no redirects, no acks; exited only by reset.
- Exception latency: redirect_o asserts exactly 1 cycle after the triggering cycle. ERET latency: redirect_o asserts 1 cycle after eret_i is accepted.
- Simultaneous events: not_an_instr_i and eret_i both set -> treated as invalid opcode (esr=1). IRQ coincident with any instruction exception -> instruction exception wins, no irq_ack_o.
- Bubbles: flags with valid_i=0 have no effect in any state.
- esr and elr hold their values after RET until the next exception capture.
- Reset mid-operation, from any state including TAKE/RET: next cycle is RUN with registers cleared and no redirect pulse.
- mrs_data_o mapping:
  - mrs_sel_i=00 -> elr.
  - mrs_sel_i=01 -> esr zero-extended to N.
  - mrs_sel_i=10 -> {N-2 zeros, fatal_o, in_handler_o}.
  - mrs_sel_i=11 -> 0.

Test Plan:
- Invalid opcode: valid_i=1, pc_i=0x40, not_an_instr_i=1 at cycle k -> cycle k+1 shows redirect_o=1, flush_o=1, redirect_pc_o=0xD8; cycle k+2 in_handler_o=1; MRS sel 00 -> 0x40, sel 01 -> 0x1.
- Return: from HANDLER, valid_i=1, eret_i=1 at cycle m -> cycle m+1 shows redirect_o=1, redirect_pc_o=0x40; cycle m+2 in_handler_o=0 with esr still 0x1.
- IRQ: irq_i=1 in RUN with pc_i=0x100 -> same cycle irq_ack_o=1, next cycle redirect to 0xD8, esr=0x2. Holding irq_i high in HANDLER -> no further ack until after RET.
- Priority and bubbles: not_an_instr_i=1 and irq_i=1 same cycle -> esr=0x1, no irq_ack_o. not_an_instr_i=1 with valid_i=0 -> no redirect, state stays RUN.
- Illegal ERET and double fault: eret_i in RUN at pc 0x80 -> esr=0x3, redirect to 0xD8. Then not_an_instr_i in HANDLER -> fatal_o=1, esr=0xF, elr=0x80; ERET afterwards gives no redirect.
- Reset mid-operation: assert reset during the TAKE cycle -> next cycle redirect_o=0, in_handler_o=0, fatal_o=0, MRS sel 00/01 both read 0.
